// File: rtl/seq_bist_pkg.sv
// Shared types and constants for the sequential pattern BIST controller.
// Holds the FSM state encoding, LFSR taps, MISR polynomial and default widths.
package seq_bist_pkg;

    localparam int LFSR_W_DEF = 8;
    localparam int MISR_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // Taps at bits 7,5,4,3 of the pattern LFSR (x^8 + x^6 + x^5 + x^4 + 1).
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/seq_pattern_bist_ctrl_if.sv
// Bundle of control, status and downstream-stage signals around the BIST controller.
// The master side is whoever drives the run and models the downstream stage.
interface seq_pattern_bist_ctrl_if
    import seq_bist_pkg::*;
#(
    parameter int LFSR_W = LFSR_W_DEF,
    parameter int MISR_W = MISR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_patterns;
    logic [LFSR_W-1:0] seed;
    logic [MISR_W-1:0] expected_sig;
    logic              dut_resp;
    logic              pat_in_1;
    logic              pat_in_2;
    logic              pat_in_5;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;

    modport master (
        output start, abort, num_patterns, seed, expected_sig, dut_resp,
        input  pat_in_1, pat_in_2, pat_in_5, busy, done, pass, signature
    );

    modport slave (
        input  start, abort, num_patterns, seed, expected_sig, dut_resp,
        output pat_in_1, pat_in_2, pat_in_5, busy, done, pass, signature
    );
endinterface

// File: rtl/seq_bist_misr.sv
// Single-input signature register compacting the downstream response stream.
// A synchronous clear wins over enable so a new run always starts from zero.
module seq_bist_misr
    import seq_bist_pkg::*;
#(
    parameter int W = MISR_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         din,
    input  logic         clear,
    output logic [W-1:0] sig
);

    logic [W-1:0] r_sig;
    logic [W-1:0] w_sig_next;
    logic         w_fb;

    always_comb begin
        w_fb       = r_sig[W-1] ^ din;
        w_sig_next = (r_sig << 1) ^ (w_fb ? W'(MISR_POLY) : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sig <= '0;
        end else if (clear) begin
            r_sig <= '0;
        end else if (enable) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/seq_pattern_bist_ctrl.sv
// Drives LFSR patterns into a one-cycle-latency downstream stage and compacts its
// responses into a MISR, reporting pass/fail against a golden signature.
module seq_pattern_bist_ctrl
    import seq_bist_pkg::*;
#(
    parameter int LFSR_W = LFSR_W_DEF,
    parameter int MISR_W = MISR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [LFSR_W-1:0] seed,
    input  logic [MISR_W-1:0] expected_sig,
    input  logic              dut_resp,
    output logic              pat_in_1,
    output logic              pat_in_2,
    output logic              pat_in_5,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    bist_state_t       r_state;
    bist_state_t       w_state_next;
    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  w_num_next;
    logic [CNT_W-1:0]  w_last;
    logic              r_pass;
    logic              w_pass_next;
    logic              w_start_ok;
    logic              w_lfsr_fb;
    logic              w_misr_clear;
    logic              w_misr_en;
    logic              w_misr_fb;
    logic [MISR_W-1:0] w_misr_next;

    assign w_start_ok = start & ~abort;
    assign w_last     = r_num - CNT_W'(1);
    assign w_lfsr_fb  = ^(r_lfsr & LFSR_W'(LFSR_TAPS));

    // Signature value after the DRAIN capture, so pass can be registered on DONE entry.
    assign w_misr_fb   = signature[MISR_W-1] ^ dut_resp;
    assign w_misr_next = (signature << 1) ^ (w_misr_fb ? MISR_W'(MISR_POLY) : '0);

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_state <= ST_IDLE;
            r_lfsr  <= LFSR_W'(1);
            r_cnt   <= '0;
            r_num   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_cnt   <= w_cnt_next;
            r_num   <= w_num_next;
            r_pass  <= w_pass_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_cnt_next   = r_cnt;
        w_num_next   = r_num;
        w_pass_next  = r_pass;
        w_misr_clear = 1'b0;
        w_misr_en    = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_misr_clear = 1'b1;
                    w_cnt_next   = '0;
                    w_num_next   = num_patterns;
                    w_lfsr_next  = (seed == '0) ? LFSR_W'(1) : seed;
                    if (num_patterns == '0) begin
                        w_state_next = ST_DONE;
                        w_pass_next  = (expected_sig == '0);
                    end else begin
                        w_state_next = ST_RUN;
                        w_pass_next  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                    w_pass_next  = 1'b0;
                end else begin
                    // Response to the first pattern only arrives one cycle later.
                    w_misr_en   = (r_cnt != '0);
                    w_lfsr_next = {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
                    if (r_cnt == w_last) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                    w_pass_next  = 1'b0;
                end else begin
                    w_misr_en    = 1'b1;
                    w_state_next = ST_DONE;
                    w_pass_next  = (w_misr_next == expected_sig);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    seq_bist_misr #(
        .W(MISR_W)
    ) u_misr (
        .clk    (blif_clk_net),
        .reset  (blif_reset_net),
        .enable (w_misr_en),
        .din    (dut_resp),
        .clear  (w_misr_clear),
        .sig    (signature)
    );

    assign pat_in_1 = (r_state == ST_RUN) & r_lfsr[0];
    assign pat_in_2 = (r_state == ST_RUN) & r_lfsr[1];
    assign pat_in_5 = (r_state == ST_RUN) & r_lfsr[2];
    assign busy     = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign pass     = r_pass;

endmodule

// File: doc/seq_pattern_bist_ctrl.md
SEQ_PATTERN_BIST_CTRL -- requirements
Module: seq_pattern_bist_ctrl

Interface
REQ-001 SHALL have parameter LFSR_W, default 8, pattern LFSR width.
REQ-002 SHALL have parameter MISR_W, default 16, response signature width.
REQ-003 SHALL have parameter CNT_W, default 16, pattern-count width.
REQ-004 SHALL have port blif_clk_net  in  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port blif_reset_net  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle run request.
REQ-007 SHALL have port abort  in  1  cancel the run in progress.
REQ-008 SHALL have port num_patterns  in  CNT_W  number of patterns N to apply.
REQ-009 SHALL have port seed  in  LFSR_W  LFSR start value.
REQ-010 SHALL have port expected_sig  in  MISR_W  golden signature.
REQ-011 SHALL have port dut_resp  in  1  downstream stage response (its n_388 output).
REQ-012 SHALL have ports pat_in_1, pat_in_2, pat_in_5  out  1 each  drive downstream IN_1, IN_2, IN_5.
REQ-013 SHALL have port busy  out  1  high in RUN or DRAIN.
REQ-014 SHALL have port done  out  1  high in DONE.
REQ-015 SHALL have port pass  out  1  signature == expected_sig; valid while done.
REQ-016 SHALL have port signature  out  MISR_W  current MISR value.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE/DONE + start with N>0 SHALL load lfsr=seed (0x01 if seed==0), cnt=0, misr=0, clear done/pass, go RUN.
REQ-019 IDLE/DONE + start with N==0 SHALL go DONE directly with misr=0, pass=(expected_sig==0).
REQ-020 start in RUN or DRAIN SHALL be ignored.
REQ-021 In RUN, {pat_in_5,pat_in_2,pat_in_1} SHALL equal lfsr[2:0]; outside RUN all three SHALL be 0.
REQ-022 LFSR SHALL be Fibonacci, shift left, new bit0 = l[7]^l[5]^l[4]^l[3], advancing once per RUN cycle.
REQ-023 RUN SHALL last exactly N cycles (cnt 0..N-1), then one DRAIN cycle, then DONE.
REQ-024 Downstream latency is 1: MISR SHALL capture dut_resp in the cycle after each RUN cycle (RUN cycles 2..N plus DRAIN), exactly N captures.
REQ-025 MISR update SHALL be fb = sig[15]^dut_resp; sig = (sig<<1) ^ (fb ? 0x1021 : 0).
REQ-026 pass SHALL be registered on DONE entry and held until next start.
REQ-027 Timing: start at cycle T -> RUN T+1..T+N, DRAIN T+N+1, done high from T+N+2.
REQ-028 abort in RUN/DRAIN SHALL return to IDLE next cycle, done=0, pass=0, signature held; abort has priority over start.
REQ-029 cnt SHALL not wrap; N=2^CNT_W-1 SHALL run to completion.

Reset
REQ-030 blif_reset_net high SHALL immediately force IDLE, lfsr=0x01, misr=0, cnt=0, all outputs 0, regardless of state.
REQ-031 Reset mid-run SHALL discard the run; no done pulse after release.

Structure
REQ-032 Package seq_bist_pkg SHALL hold the state enum, LFSR tap mask, MISR polynomial 0x1021 and width defaults.
REQ-033 MISR SHALL be one sub-module seq_bist_misr (clk, reset, enable, din, clear, sig).

Verification
REQ-034 seed=0x01, N=5 -> {pat_in_5,pat_in_2,pat_in_1} = 001,010,100,000,001 on cycles T+1..T+5.
REQ-035 dut_resp tied 1, N=2, expected 0x3063 -> signature 0x3063, pass=1, done at T+4.
REQ-036 dut_resp tied 0, N=4, expected 0x0001 -> signature 0x0000, pass=0.
REQ-037 N=0, expected 0 -> done at T+1, pass=1, no pattern toggles.
REQ-038 abort at T+3 of N=10 run -> IDLE at T+4, done never asserts; second start during RUN ignored.
REQ-039 reset pulse at T+2 of N=8 run -> outputs 0 asynchronously, IDLE after release.
